memaccess_ctrl: RTL and testbench

Sequential memory-access stage controller for the LC-3 datapath. It accepts one load or store request per handshake (direct or indirect), sequences the data-memory bus (DMem_addr, DMem_din, DMem_rd, DMem_we), and returns loaded data on memout with a one-cycle resp_valid pulse. It drives the signals monitored by the memaccess_out agent and feeds the writeback stage.

---
 rtl/memaccess_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_memaccess_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess_ctrl.sv
`timescale 1ns/1ps
// Memory-access stage controller: sequences LD/ST/LDI/STI over the data-memory bus
// and returns loaded words on memout with a one-cycle resp_valid pulse.
module memaccess_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1    // legal range 1..7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] DMem_dout,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  output logic              DMem_rd,
  output logic              DMem_we,
  output logic [DATA_W-1:0] memout,
  output logic              resp_valid,
  output logic [1:0]        resp_op
);

  typedef enum logic [2:0] {IDLE, RD_IND, RD_DATA, WR_DATA, DONE} state_e;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;
  localparam logic [4:0] LAST_CNT = 5'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_din_q, dmem_din_d;
  logic              dmem_rd_q, dmem_rd_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              resp_valid_q, resp_valid_d;
  logic [1:0]        resp_op_q, resp_op_d;
  logic              req_ready_q, req_ready_d;
  logic              rd_last;

  assign rd_last = (cnt_q == LAST_CNT);

  // Outputs are computed for the next state so every strobe leaves a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    data_d       = data_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_din_d   = dmem_din_q;
    dmem_rd_d    = 1'b0;
    dmem_we_d    = 1'b0;
    memout_d     = memout_q;
    resp_valid_d = 1'b0;
    resp_op_d    = resp_op_q;
    req_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d        = req_op;
          data_d      = req_data;
          dmem_addr_d = req_addr;
          cnt_d       = '0;
          case (req_op)
            OP_LD: begin
              state_d   = RD_DATA;
              dmem_rd_d = 1'b1;
            end
            OP_ST: begin
              state_d    = WR_DATA;
              dmem_we_d  = 1'b1;
              dmem_din_d = req_data;
            end
            OP_LDI, OP_STI: begin
              state_d   = RD_IND;
              dmem_rd_d = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RD_IND: begin
        if (rd_last) begin
          cnt_d       = '0;
          dmem_addr_d = ADDR_W'(DMem_dout);
          if (op_q == OP_LDI) begin
            state_d   = RD_DATA;
            dmem_rd_d = 1'b1;
          end else begin
            state_d    = WR_DATA;
            dmem_we_d  = 1'b1;
            dmem_din_d = data_q;
          end
        end else begin
          cnt_d     = cnt_q + 5'd1;
          dmem_rd_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (rd_last) begin
          memout_d     = DMem_dout;
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_op_d    = op_q;
        end else begin
          cnt_d     = cnt_q + 5'd1;
          dmem_rd_d = 1'b1;
        end
      end
      WR_DATA: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_op_d    = op_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort drops the request; a write already on the bus commits at this same edge.
    if (flush) begin
      state_d      = IDLE;
      cnt_d        = '0;
      op_d         = op_q;
      data_d       = data_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_din_d   = dmem_din_q;
      dmem_rd_d    = 1'b0;
      dmem_we_d    = 1'b0;
      memout_d     = memout_q;
      resp_valid_d = 1'b0;
      resp_op_d    = resp_op_q;
    end

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      data_q       <= '0;
      dmem_addr_q  <= '0;
      dmem_din_q   <= '0;
      dmem_rd_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      memout_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      data_q       <= data_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_din_q   <= dmem_din_d;
      dmem_rd_q    <= dmem_rd_d;
      dmem_we_q    <= dmem_we_d;
      memout_q     <= memout_d;
      resp_valid_q <= resp_valid_d;
      resp_op_q    <= resp_op_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign DMem_addr  = dmem_addr_q;
  assign DMem_din   = dmem_din_q;
  assign DMem_rd    = dmem_rd_q;
  assign DMem_we    = dmem_we_q;
  assign memout     = memout_q;
  assign resp_valid = resp_valid_q;
  assign resp_op    = resp_op_q;

endmodule

// File: tb/tb_memaccess_ctrl.sv
`timescale 1ns/1ps
// Bench for memaccess_ctrl: instance 0 uses READ_LAT=1, instance 1 READ_LAT=3, each with
// its own combinational-read memory; responses are matched against a scoreboard queue.
module tb_memaccess_ctrl;

  typedef struct {
    int         sel;
    logic [1:0] op;
    logic [15:0] memout;
    int         cyc;
  } exp_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;

  logic        clock;
  logic        rst_n      [2];
  logic        flush      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [1:0]  req_op     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_data   [2];
  logic [15:0] dmem_addr  [2];
  logic [15:0] dmem_din   [2];
  logic        dmem_rd    [2];
  logic        dmem_we    [2];
  logic [15:0] memout     [2];
  logic        resp_valid [2];
  logic [1:0]  resp_op    [2];

  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] mem [0:65535];

    always @(posedge clock) begin
      if (dmem_we[gi] === 1'b1) mem[dmem_addr[gi]] <= dmem_din[gi];
      else if (pl_en) mem[pl_addr] <= pl_data;
    end

    memaccess_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LAT(gi == 0 ? 1 : 3)) u_dut (
      .clock      (clock),
      .reset      (rst_n[gi]),
      .flush      (flush[gi]),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_op     (req_op[gi]),
      .req_addr   (req_addr[gi]),
      .req_data   (req_data[gi]),
      .DMem_dout  (mem[dmem_addr[gi]]),
      .DMem_addr  (dmem_addr[gi]),
      .DMem_din   (dmem_din[gi]),
      .DMem_rd    (dmem_rd[gi]),
      .DMem_we    (dmem_we[gi]),
      .memout     (memout[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_op    (resp_op[gi])
    );

    always @(posedge clock)
      if (req_valid[gi] === 1'b1)
        assert (!$isunknown(req_op[gi])) else $error("req_op unknown while req_valid, inst %0d", gi);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every completion pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (resp_valid[i] === 1'b1) begin
        check_eq("resp_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_eq("resp_inst", i, mon_e.sel);
          check_eq("resp_op", resp_op[i], mon_e.op);
          check_eq("resp_memout", memout[i], mon_e.memout);
          check_eq("resp_cycle", cyc, mon_e.cyc);
          $display("resp inst%0d op=%0d memout=0x%h cyc=%0d", i, resp_op[i], memout[i], cyc);
        end
      end
    end
  end

  task automatic wait_ready(input int sel);
    int n = 0;
    while (req_ready[sel] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq("ready_before_req", req_ready[sel], 1);
  endtask

  task automatic drive_accept(input int sel, input logic [1:0] op,
                              input logic [15:0] addr, input logic [15:0] data);
    req_valid[sel] = 1'b1;
    req_op[sel]    = op;
    req_addr[sel]  = addr;
    req_data[sel]  = data;
    @(posedge clock);
    #1;
    req_valid[sel] = 1'b0;
    req_addr[sel]  = 16'($urandom);
    req_data[sel]  = 16'($urandom);
  endtask

  task automatic run_req(input int sel, input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] exp_mem, input int lat,
                         input int exp_rd, input logic [15:0] rd_first, input logic [15:0] rd_last,
                         input int exp_we, input logic [15:0] wr_addr, input logic [15:0] wr_din);
    int n = 0, rd_n = 0, we_n = 0;
    logic [15:0] f_addr = '0, l_addr = '0, w_addr = '0, w_din = '0;
    logic ready_hi = 1'b0, overlap = 1'b0, done = 1'b0;
    exp_t e;
    @(negedge clock);
    wait_ready(sel);
    drive_accept(sel, op, addr, data);
    e.sel = sel; e.op = op; e.memout = exp_mem; e.cyc = cyc + lat - 1;
    sb_q.push_back(e);
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
      if (req_ready[sel] !== 1'b0) ready_hi = 1'b1;
      if (dmem_rd[sel] === 1'b1 && dmem_we[sel] === 1'b1) overlap = 1'b1;
      if (dmem_rd[sel] === 1'b1) begin
        if (rd_n == 0) f_addr = dmem_addr[sel];
        l_addr = dmem_addr[sel];
        rd_n++;
      end
      if (dmem_we[sel] === 1'b1) begin
        w_addr = dmem_addr[sel];
        w_din  = dmem_din[sel];
        we_n++;
      end
      if (resp_valid[sel] === 1'b1) done = 1'b1;
    end
    $display("req inst%0d op=%0d addr=0x%h data=0x%h latency=%0d rd_cycles=%0d we_cycles=%0d",
             sel, op, addr, data, n, rd_n, we_n);
    check_eq("resp_seen", done, 1);
    check_eq("latency", n, lat);
    check_eq("ready_low_while_busy", ready_hi, 0);
    check_eq("rd_we_overlap", overlap, 0);
    check_eq("rd_cycles", rd_n, exp_rd);
    check_eq("we_cycles", we_n, exp_we);
    if (exp_rd > 0) begin
      check_eq("rd_first_addr", f_addr, rd_first);
      check_eq("rd_last_addr", l_addr, rd_last);
    end
    if (exp_we > 0) begin
      check_eq("wr_addr", w_addr, wr_addr);
      check_eq("wr_din", w_din, wr_din);
    end
    @(negedge clock);
    check_eq("resp_one_cycle", resp_valid[sel], 0);
    check_eq("ready_after_done", req_ready[sel], 1);
  endtask

  task automatic check_cleared(input int sel);
    check_eq("clr_rd", dmem_rd[sel], 0);
    check_eq("clr_we", dmem_we[sel], 0);
    check_eq("clr_addr", dmem_addr[sel], 0);
    check_eq("clr_din", dmem_din[sel], 0);
    check_eq("clr_memout", memout[sel], 0);
    check_eq("clr_resp_valid", resp_valid[sel], 0);
    check_eq("clr_resp_op", resp_op[sel], 0);
  endtask

  // Abort at the edge ending the k-th cycle after accept, via flush or reset.
  task automatic abort_req(input int sel, input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] data, input int k, input bit use_rst,
                           input logic [15:0] exp_mem);
    int resp_n = 0;
    @(negedge clock);
    wait_ready(sel);
    drive_accept(sel, op, addr, data);
    repeat (k) @(negedge clock);
    if (use_rst) rst_n[sel] = 1'b0;
    else flush[sel] = 1'b1;
    @(negedge clock);
    rst_n[sel] = 1'b1;
    flush[sel] = 1'b0;
    check_eq("abort_rd", dmem_rd[sel], 0);
    check_eq("abort_we", dmem_we[sel], 0);
    check_eq("abort_resp_valid", resp_valid[sel], 0);
    check_eq("abort_memout", memout[sel], exp_mem);
    if (use_rst) check_cleared(sel);
    else check_eq("abort_ready_next", req_ready[sel], 1);
    repeat (6) begin
      @(negedge clock);
      if (resp_valid[sel] !== 1'b0) resp_n++;
    end
    $display("abort inst%0d op=%0d addr=0x%h cycle=%0d by=%s", sel, op, addr, k,
             use_rst ? "reset" : "flush");
    check_eq("abort_no_resp", resp_n, 0);
    check_eq("abort_ready_idle", req_ready[sel], 1);
  endtask

  task automatic idle_flush(input int sel);
    int resp_n = 0;
    @(negedge clock);
    req_valid[sel] = 1'b1;
    req_op[sel]    = OP_LD;
    req_addr[sel]  = 16'h4000;
    flush[sel]     = 1'b1;
    @(negedge clock);
    req_valid[sel] = 1'b0;
    flush[sel]     = 1'b0;
    check_eq("idle_flush_no_rd", dmem_rd[sel], 0);
    check_eq("idle_flush_ready", req_ready[sel], 1);
    repeat (4) begin
      @(negedge clock);
      if (resp_valid[sel] !== 1'b0) resp_n++;
    end
    $display("idle flush inst%0d with req_valid=1", sel);
    check_eq("idle_flush_no_resp", resp_n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; flush[i] = 1'b0; req_valid[i] = 1'b0;
      req_op[i] = '0; req_addr[i] = '0; req_data[i] = '0;
    end
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clock);
    pl_en = 1'b1; pl_addr = 16'h3000; pl_data = 16'h4000;
    @(negedge clock);
    pl_addr = 16'h4000; pl_data = 16'hBEEF;
    @(negedge clock);
    pl_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_cleared(i);
      check_eq("reset_ready", req_ready[i], 1);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // READ_LAT = 1
    run_req(0, OP_LD,  16'h4000, 16'h0000, 16'hBEEF, 2, 1, 16'h4000, 16'h4000, 0, 16'h0, 16'h0);
    run_req(0, OP_LDI, 16'h3000, 16'h0000, 16'hBEEF, 3, 2, 16'h3000, 16'h4000, 0, 16'h0, 16'h0);
    run_req(0, OP_ST,  16'h3010, 16'h1234, 16'hBEEF, 2, 0, 16'h0, 16'h0, 1, 16'h3010, 16'h1234);
    run_req(0, OP_LD,  16'h3010, 16'h0000, 16'h1234, 2, 1, 16'h3010, 16'h3010, 0, 16'h0, 16'h0);
    run_req(0, OP_STI, 16'h3000, 16'hA5A5, 16'h1234, 3, 1, 16'h3000, 16'h3000, 1, 16'h4000, 16'hA5A5);
    run_req(0, OP_LD,  16'h4000, 16'h0000, 16'hA5A5, 2, 1, 16'h4000, 16'h4000, 0, 16'h0, 16'h0);
    idle_flush(0);
    abort_req(0, OP_ST, 16'h3020, 16'h5555, 1, 1'b0, 16'hA5A5);
    run_req(0, OP_LD,  16'h3020, 16'h0000, 16'h5555, 2, 1, 16'h3020, 16'h3020, 0, 16'h0, 16'h0);

    // READ_LAT = 3
    run_req(1, OP_LDI, 16'h3000, 16'h0000, 16'hBEEF, 7, 6, 16'h3000, 16'h4000, 0, 16'h0, 16'h0);
    run_req(1, OP_LD,  16'h3000, 16'h0000, 16'h4000, 4, 3, 16'h3000, 16'h3000, 0, 16'h0, 16'h0);
    run_req(1, OP_STI, 16'h3000, 16'h7777, 16'h4000, 5, 3, 16'h3000, 16'h3000, 1, 16'h4000, 16'h7777);
    run_req(1, OP_LDI, 16'h3000, 16'h0000, 16'h7777, 7, 6, 16'h3000, 16'h4000, 0, 16'h0, 16'h0);
    abort_req(1, OP_LD,  16'h3000, 16'h0000, 2, 1'b0, 16'h7777);
    abort_req(1, OP_LDI, 16'h3000, 16'h0000, 2, 1'b1, 16'h0000);
    run_req(1, OP_LD,  16'h4000, 16'h0000, 16'h7777, 4, 3, 16'h4000, 16'h4000, 0, 16'h0, 16'h0);

    repeat (3) @(negedge clock);
    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
